adc_tape_slicer: RTL and testbench
==================================

ADC_TAPE_SLICER -- requirements
Module: adc_tape_slicer

Interface
REQ-001 SHALL have parameter DATA_W, default 12: ADC sample width, unsigned.
REQ-002 SHALL have parameter DEPTH_LOG2, default 9: log2 of running-average window; window = 2^DEPTH_LOG2 samples.
REQ-003 SHALL have parameter PW_W, default 16: period counter width.
REQ-004 SHALL have parameter INVERT, default 1: 1 means a below-average excursion drives bit_out=1 (CoCo/MC-10 polarity).
REQ-005 SHALL have port clk_sys, input, 1: the single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port enable, input, 1: 0 = ignore samples, hold all outputs.
REQ-008 SHALL have port din, input, DATA_W: ADC sample.
REQ-009 SHALL have port din_valid, input, 1: one-cycle strobe qualifying din.
REQ-010 SHALL have port hyst, input, DATA_W: hysteresis threshold, runtime value.
REQ-011 SHALL have port bit_out, output, 1: sliced cassette bit.
REQ-012 SHALL have port edge, output, 1: one-cycle pulse when bit_out changes.
REQ-013 SHALL have port avg, output, DATA_W: current window average.
REQ-014 SHALL have port period, output, PW_W: clk_sys cycles between the last two edges.
REQ-015 SHALL have port period_valid, output, 1: one-cycle pulse when period updates.
REQ-016 SHALL have port primed, output, 1: window fully filled since reset.
REQ-017 SHALL have port overrun, output, 1: sticky flag, a sample was dropped.

Function
REQ-018 SHALL accept a sample when din_valid=1, enable=1 and the pipeline is idle; acceptance is cycle 0.
REQ-019 SHALL store samples in a circular buffer of 2^DEPTH_LOG2 entries, indexed by a write pointer that wraps from 2^DEPTH_LOG2-1 to 0.
REQ-020 SHALL, in cycle 1, read the oldest entry at the write pointer; in cycle 2, write the new sample, advance the pointer, and update total = total - oldest + new.
REQ-021 SHALL size total at DATA_W+DEPTH_LOG2 bits, never overflowing or underflowing.
REQ-022 SHALL treat oldest as 0 while primed=0, so the buffer RAM needs no reset.
REQ-023 SHALL set primed on the first pointer wrap to 0; primed stays 1 until reset.
REQ-024 SHALL register avg = total >> DEPTH_LOG2 in cycle 3.
REQ-025 SHALL compare, in cycle 2, the new sample against avg as held before that update, using DATA_W+2-bit signed arithmetic so there is no wrap.
REQ-026 SHALL classify an excursion as "low" when din + hyst < avg, and as "high" when din > avg + hyst; both comparisons are strict.
REQ-027 SHALL, with INVERT=1, set bit_out to 1 on low and 0 on high; with INVERT=0 it sets the opposite values; otherwise bit_out holds.
REQ-028 SHALL perform no comparison while primed=0; bit_out stays 0.
REQ-029 SHALL update bit_out at the end of cycle 2, i.e. it is visible 3 clocks after the din_valid edge; edge pulses in the same cycle bit_out changes.
REQ-030 SHALL, for din_valid arriving while cycles 1-3 are busy, drop the sample and set overrun; the average is unaffected.
REQ-031 SHALL run a period counter that increments every clock and saturates at 2^PW_W-1.
REQ-032 SHALL, on edge, load period with the counter value, clear the counter to 1, and pulse period_valid.
REQ-033 SHALL suppress period_valid for the first edge after reset.
REQ-034 SHALL, with enable=0, accept no samples, freeze the period counter, and let an in-flight sample complete.

Reset
REQ-035 SHALL clear, on reset, bit_out, edge, avg, period, period_valid, primed, overrun, total, the write pointer, the pipeline stage and the period counter to 0, plus the first-edge flag; buffer contents are not reset.
REQ-036 SHALL abandon any in-flight sample when reset is asserted mid-pipeline; no buffer write occurs.

Structure
REQ-037 SHALL place the default DATA_W, DEPTH_LOG2 and PW_W constants and the pipeline-stage enum (IDLE, READ, UPDATE, AVG) in the shared package mc10_tape_pkg.
REQ-038 SHALL implement the circular buffer as one sub-module, tape_avg_ram: a simple dual-port inferred RAM with registered read.

Verification (DATA_W=12, DEPTH_LOG2=2, hyst=100, INVERT=1)
REQ-039 SHALL check: assert reset mid-sample -> all outputs 0, and the next accepted sample is written at pointer 0.
REQ-040 SHALL check: four samples of 2048, spaced 4 clocks apart -> primed=1 after the 4th, avg=2048, bit_out=0, no edge.
REQ-041 SHALL check: after priming, send 1900 -> bit_out=1 and edge 3 clocks later; then 2100 -> bit_out holds 1; then 2200 -> bit_out=0 with edge.
REQ-042 SHALL check: avg=50, sample 0 -> no toggle (0+100 < 50 is false); and avg=4050, sample 4095 -> no toggle, with no arithmetic wrap.
REQ-043 SHALL check: din_valid on two consecutive clocks -> second sample dropped, overrun=1, avg reflects the first sample only.
REQ-044 SHALL check: edges 1000 clocks apart -> period=1000 with period_valid; a gap over 65535 clocks -> period=65535; the first edge after reset gives no period_valid.

Source files
------------

// File: rtl/mc10_tape_pkg.sv
// Shared constants and pipeline stage encoding for the cassette tape slicer.
package mc10_tape_pkg;

  localparam int unsigned DefDataW     = 12;
  localparam int unsigned DefDepthLog2 = 9;
  localparam int unsigned DefPwW       = 16;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    UPDATE,
    AVG
  } stage_e;

endpackage

// File: rtl/tape_avg_ram.sv
// Circular sample buffer: simple dual-port RAM, registered read, no reset.
module tape_avg_ram
  import mc10_tape_pkg::*;
#(
  parameter int unsigned AddrW = DefDepthLog2,
  parameter int unsigned DataW = DefDataW
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [DataW-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [DataW-1:0] rdata_o
);

  localparam int unsigned Depth = 2 ** AddrW;

  logic [DataW-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/adc_tape_slicer.sv
// Cassette ADC slicer: running-average baseline with hysteresis compare, plus
// bit-period measurement between successive transitions.
module adc_tape_slicer
  import mc10_tape_pkg::*;
#(
  parameter int unsigned DATA_W     = DefDataW,
  parameter int unsigned DEPTH_LOG2 = DefDepthLog2,
  parameter int unsigned PW_W       = DefPwW,
  parameter int unsigned INVERT     = 1
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              enable,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  input  logic [DATA_W-1:0] hyst,
  output logic              bit_out,
  output logic              edge_o,
  output logic [DATA_W-1:0] avg,
  output logic [PW_W-1:0]   period,
  output logic              period_valid,
  output logic              primed,
  output logic              overrun
);

  localparam int unsigned TotW = DATA_W + DEPTH_LOG2;
  localparam int unsigned CmpW = DATA_W + 2;

  stage_e                stage_q, stage_d;
  logic [DATA_W-1:0]     sample_q, sample_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [TotW-1:0]       total_q, total_d;
  logic [DATA_W-1:0]     avg_q, avg_d;
  logic                  bit_q, bit_d;
  logic                  edge_q, edge_d;
  logic [PW_W-1:0]       period_q, period_d;
  logic [PW_W-1:0]       cnt_q, cnt_d;
  logic                  pvalid_q, pvalid_d;
  logic                  primed_q, primed_d;
  logic                  overrun_q, overrun_d;
  logic                  seen_q, seen_d;

  logic                  ram_we;
  logic [DATA_W-1:0]     ram_rdata;
  logic [DATA_W-1:0]     oldest;
  logic signed [CmpW-1:0] din_s, avg_s, hyst_s;
  logic                  is_low, is_high;

  tape_avg_ram #(
    .AddrW (DEPTH_LOG2),
    .DataW (DATA_W)
  ) u_ram (
    .clk_i   (clk_sys),
    .we_i    (ram_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (sample_q),
    .raddr_i (wr_ptr_q),
    .rdata_o (ram_rdata)
  );

  // Unwritten RAM entries are never trusted before the first wrap.
  assign oldest = primed_q ? ram_rdata : '0;

  // Zero-extended signed compare so din+hyst and avg+hyst cannot wrap.
  assign din_s   = $signed({2'b00, sample_q});
  assign avg_s   = $signed({2'b00, avg_q});
  assign hyst_s  = $signed({2'b00, hyst});
  assign is_low  = (din_s + hyst_s) < avg_s;
  assign is_high = din_s > (avg_s + hyst_s);

  always_comb begin
    stage_d   = stage_q;
    sample_d  = sample_q;
    wr_ptr_d  = wr_ptr_q;
    total_d   = total_q;
    avg_d     = avg_q;
    bit_d     = bit_q;
    edge_d    = 1'b0;
    period_d  = period_q;
    cnt_d     = cnt_q;
    pvalid_d  = 1'b0;
    primed_d  = primed_q;
    overrun_d = overrun_q;
    seen_d    = seen_q;
    ram_we    = 1'b0;

    if (enable && (cnt_q != '1)) begin
      cnt_d = cnt_q + PW_W'(1);
    end

    if (din_valid && enable) begin
      if (stage_q == IDLE) begin
        sample_d = din;
        stage_d  = READ;
      end else begin
        overrun_d = 1'b1;
      end
    end

    unique case (stage_q)
      IDLE: ;
      READ: stage_d = UPDATE;
      UPDATE: begin
        ram_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
        total_d  = total_q - TotW'(oldest) + TotW'(sample_q);
        if (wr_ptr_q == '1) begin
          primed_d = 1'b1;
        end
        if (primed_q) begin
          if (is_low) begin
            bit_d = (INVERT != 0);
          end else if (is_high) begin
            bit_d = (INVERT == 0);
          end
        end
        stage_d = AVG;
      end
      AVG: begin
        avg_d   = total_q[TotW-1:DEPTH_LOG2];
        stage_d = IDLE;
      end
      default: stage_d = IDLE;
    endcase

    // The counter value at a transition is the distance from the previous one.
    if (bit_d != bit_q) begin
      edge_d   = 1'b1;
      period_d = cnt_q;
      cnt_d    = PW_W'(1);
      pvalid_d = seen_q;
      seen_d   = 1'b1;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      stage_q   <= IDLE;
      sample_q  <= '0;
      wr_ptr_q  <= '0;
      total_q   <= '0;
      avg_q     <= '0;
      bit_q     <= 1'b0;
      edge_q    <= 1'b0;
      period_q  <= '0;
      cnt_q     <= '0;
      pvalid_q  <= 1'b0;
      primed_q  <= 1'b0;
      overrun_q <= 1'b0;
      seen_q    <= 1'b0;
    end else begin
      stage_q   <= stage_d;
      sample_q  <= sample_d;
      wr_ptr_q  <= wr_ptr_d;
      total_q   <= total_d;
      avg_q     <= avg_d;
      bit_q     <= bit_d;
      edge_q    <= edge_d;
      period_q  <= period_d;
      cnt_q     <= cnt_d;
      pvalid_q  <= pvalid_d;
      primed_q  <= primed_d;
      overrun_q <= overrun_d;
      seen_q    <= seen_d;
    end
  end

  assign bit_out      = bit_q;
  assign edge_o       = edge_q;
  assign avg          = avg_q;
  assign period       = period_q;
  assign period_valid = pvalid_q;
  assign primed       = primed_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_adc_tape_slicer.sv
// Scoreboard bench for adc_tape_slicer: sliding-window reference model feeds an
// expectation queue that a negedge monitor drains.
module tb_adc_tape_slicer;

  localparam int unsigned DW = 12;
  localparam int unsigned DL = 2;
  localparam int unsigned PW = 16;
  localparam int WinN   = 1 << DL;
  localparam int PerMax = (1 << PW) - 1;

  logic          clk_sys = 1'b0;
  logic          reset;
  logic          enable;
  logic [DW-1:0] din;
  logic          din_valid;
  logic [DW-1:0] hyst;
  logic          bit_out;
  logic          edge_o;
  logic [DW-1:0] avg;
  logic [PW-1:0] period;
  logic          period_valid;
  logic          primed;
  logic          overrun;

  adc_tape_slicer #(
    .DATA_W     (DW),
    .DEPTH_LOG2 (DL),
    .PW_W       (PW),
    .INVERT     (1)
  ) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .enable       (enable),
    .din          (din),
    .din_valid    (din_valid),
    .hyst         (hyst),
    .bit_out      (bit_out),
    .edge_o       (edge_o),
    .avg          (avg),
    .period       (period),
    .period_valid (period_valid),
    .primed       (primed),
    .overrun      (overrun)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    int due;
    bit kind;       // 0: bit/edge/period check, 1: avg/primed check
    bit e_bit;
    bit e_edge;
    bit e_pv;
    int e_period;
    int e_avg;
    bit e_primed;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  // Reference model: last WinN accepted samples, missing ones counting as 0.
  int win[$];
  int m_cnt;
  int m_avg;
  int m_last_edge;
  bit m_bit;
  bit m_seen;

  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    win.delete();
    m_cnt       = 0;
    m_avg       = 0;
    m_last_edge = 0;
    m_bit       = 1'b0;
    m_seen      = 1'b0;
  endtask

  task automatic model_accept(input int v);
    int   t, sum, per;
    bit   nb, pv;
    exp_t e;
    nb = m_bit;
    if (m_cnt >= WinN) begin
      if (v + int'(hyst) < m_avg) nb = 1'b1;
      else if (v > m_avg + int'(hyst)) nb = 1'b0;
    end
    win.push_back(v);
    if (win.size() > WinN) void'(win.pop_front());
    m_cnt++;
    sum = 0;
    foreach (win[i]) sum += win[i];
    m_avg = sum / WinN;
    t   = cyc + 3;
    pv  = 1'b0;
    per = 0;
    if (nb != m_bit) begin
      if (m_seen) begin
        pv  = 1'b1;
        per = t - m_last_edge;
        if (per > PerMax) per = PerMax;
      end
      m_seen      = 1'b1;
      m_last_edge = t;
    end
    e.due      = t;
    e.kind     = 1'b0;
    e.e_bit    = nb;
    e.e_edge   = (nb != m_bit);
    e.e_pv     = pv;
    e.e_period = per;
    e.e_avg    = 0;
    e.e_primed = 1'b0;
    exp_q.push_back(e);
    e.due      = t + 1;
    e.kind     = 1'b1;
    e.e_avg    = m_avg;
    e.e_primed = (m_cnt >= WinN);
    exp_q.push_back(e);
    m_bit = nb;
  endtask

  // Called at a negedge; returns at the negedge 4 clocks later.
  task automatic send(input int v);
    din       = DW'(v);
    din_valid = 1'b1;
    model_accept(v);
    @(negedge clk_sys);
    din_valid = 1'b0;
    repeat (3) @(negedge clk_sys);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " bit_out"}, int'(bit_out), 0);
    check({tag, " edge"}, int'(edge_o), 0);
    check({tag, " avg"}, int'(avg), 0);
    check({tag, " period"}, int'(period), 0);
    check({tag, " period_valid"}, int'(period_valid), 0);
    check({tag, " primed"}, int'(primed), 0);
    check({tag, " overrun"}, int'(overrun), 0);
  endtask

  exp_t cur;
  bit   due0;

  always @(negedge clk_sys) begin
    if (!reset) begin
      due0 = 1'b0;
      while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        cur = exp_q.pop_front();
        if (cur.due < cyc) begin
          check("expectation expired", cyc, cur.due);
        end else if (!cur.kind) begin
          due0 = 1'b1;
          check("bit_out", int'(bit_out), int'(cur.e_bit));
          check("edge", int'(edge_o), int'(cur.e_edge));
          check("period_valid", int'(period_valid), int'(cur.e_pv));
          if (cur.e_pv) check("period", int'(period), cur.e_period);
        end else begin
          check("avg", int'(avg), cur.e_avg);
          check("primed", int'(primed), int'(cur.e_primed));
        end
      end
      if (!due0) begin
        check("spurious edge", int'(edge_o), 0);
        check("spurious period_valid", int'(period_valid), 0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int v;
    reset     = 1'b1;
    enable    = 1'b1;
    din_valid = 1'b0;
    din       = '0;
    hyst      = 12'd100;
    model_reset();
    repeat (3) @(negedge clk_sys);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk_sys);

    // Prime with a flat baseline.
    repeat (4) send(2048);
    check("primed after 4th", int'(primed), 1);

    // Low excursion, inside hysteresis, high excursion.
    send(1900);
    send(2100);
    send(2200);

    // Period: 1000 clocks apart, then a saturating gap.
    repeat (4) send(2048);
    c0 = cyc;
    send(0);
    while (cyc < c0 + 1000) @(negedge clk_sys);
    c0 = cyc;
    send(4095);
    while (cyc < c0 + 66000) @(negedge clk_sys);
    send(0);

    // Compare boundaries at both ends of the range.
    repeat (4) send(50);
    send(0);
    repeat (4) send(4050);
    send(4095);

    // Randomized samples and hysteresis.
    for (int i = 0; i < 40; i++) begin
      hyst = DW'($urandom_range(0, 300));
      send(int'($urandom_range(0, 4095)));
      repeat ($urandom_range(0, 3)) @(negedge clk_sys);
    end
    hyst = 12'd100;

    // In-flight sample completes with enable low; new samples are ignored.
    v         = m_avg;
    din       = DW'(v);
    din_valid = 1'b1;
    model_accept(v);
    @(negedge clk_sys);
    din_valid = 1'b0;
    enable    = 1'b0;
    repeat (2) @(negedge clk_sys);
    din       = 12'd4095;
    din_valid = 1'b1;
    @(negedge clk_sys);
    din_valid = 1'b0;
    repeat (3) @(negedge clk_sys);
    check("avg while disabled", int'(avg), m_avg);
    check("overrun while disabled", int'(overrun), 0);
    enable = 1'b1;
    @(negedge clk_sys);

    // Reset while a sample is in flight.
    din       = 12'd1234;
    din_valid = 1'b1;
    @(negedge clk_sys);
    din_valid = 1'b0;
    #1 reset = 1'b1;
    exp_q.delete();
    model_reset();
    @(negedge clk_sys);
    check_all_zero("mid-sample reset");
    @(negedge clk_sys);
    reset = 1'b0;
    @(negedge clk_sys);
    send(100);
    send(200);
    send(300);
    send(400);

    // Back-to-back strobes: second one dropped.
    din       = 12'd1000;
    din_valid = 1'b1;
    model_accept(1000);
    @(negedge clk_sys);
    din = 12'd3000;
    @(negedge clk_sys);
    din_valid = 1'b0;
    repeat (3) @(negedge clk_sys);
    check("overrun sticky", int'(overrun), 1);

    repeat (4) @(negedge clk_sys);
    check("scoreboard drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
